// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply,
// restoring divide, sign applied by magnitude/negate around an unsigned core.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               b_zero;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   trial;

    // Unsigned ops (op[0]=1) never take a magnitude; most-negative maps to 2^(W-1).
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = cond_neg(a, a_neg);
    assign b_mag = cond_neg(b, b_neg);

    // acc upper half is the partial product (mul) or partial remainder (div).
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    assign trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        if (op <= 3'd3) begin
                            state  <= CALC;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            is_div <= op[1];
                            b_zero <= (b == '0);
                            neg_lo <= a_neg ^ b_neg;
                            if (op[1]) begin
                                opnd   <= b_mag;
                                acc    <= {{WIDTH{1'b0}}, a_mag};
                                neg_hi <= a_neg;
                            end else begin
                                opnd   <= a_mag;
                                acc    <= {{WIDTH{1'b0}}, b_mag};
                                neg_hi <= a_neg ^ b_neg;
                            end
                        end else if (op == 3'd4) begin
                            hi <= a;
                        end else if (op == 3'd5) begin
                            lo <= a;
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            if (!trial[WIDTH])
                                acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                            else
                                acc <= {acc[2*WIDTH-2:0], 1'b0};
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (is_div) begin
                            // Divide by zero: remainder already equals |a|, so only lo is forced.
                            lo <= b_zero ? '1 : cond_neg(acc[WIDTH-1:0], neg_lo);
                            hi <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_hi);
                        end else begin
                            {hi, lo} <= cond_neg2(acc, neg_lo);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32).
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp  = 0;
    int n_fail = 0;

    mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 00000000", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_mtx();
        issue(3'd4, 32'hAAAA5555, 32'h0);
        n_cmp++; if (hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL mthi: got %h want aaaa5555", hi); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mthi_flags: got busy=%b done=%b want 0 0", busy, done); end
        issue(3'd5, 32'h0F0F0F0F, 32'h0);
        n_cmp++; if (lo !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL mtlo: got %h want 0f0f0f0f", lo); end
        issue(3'd6, 32'hDEADBEEF, 32'h1);
        issue(3'd7, 32'hCAFEF00D, 32'h2);
        tick();
        n_cmp++; if (hi !== 32'hAAAA5555 || lo !== 32'h0F0F0F0F || busy !== 1'b0)
            begin n_fail++; $display("FAIL reserved_op: got hi=%h lo=%h busy=%b want aaaa5555 0f0f0f0f 0", hi, lo, busy); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(3'd0, 32'd5, 32'd3);
        repeat (9) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_hilo: got %h %h want 0 0", hi, lo); end
        repeat (40) begin tick(); if (done === 1'b1) seen++; end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_nodone: got %0d done pulses want 0", seen); end
    endtask

    task automatic test_multu();
        int bad = 0;
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        if (busy !== 1'b1) bad++;
        for (int i = 1; i <= 32; i++) begin
            if (hi !== 32'h0 || done !== 1'b0) bad++;
            tick();
            if (busy !== 1'b1 && i < 32) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL multu_busy: got %0d bad busy/done/hold cycles want 0", bad); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy32: got %b want 1", busy); end
        tick();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL multu_done: got done=%b busy=%b want 1 0", done, busy); end
        n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult();
        int lat;
        issue(3'd0, 32'hFFFFFFF9, 32'd6);
        wait_done(lat);
        n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL mult_lat: got %0d want 33", lat); end
        n_cmp++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL mult: got %h_%h want ffffffff_ffffffd6", hi, lo); end
    endtask

    task automatic test_div();
        int lat;
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done(lat);
        n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL div_lat: got %0d want 33", lat); end
        n_cmp++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div: got lo=%h hi=%h want fffffffd ffffffff", lo, hi); end
        tick();
        issue(3'd3, 32'd7, 32'd0);
        wait_done(lat);
        n_cmp++; if (lo !== 32'hFFFFFFFF || hi !== 32'd7) begin n_fail++; $display("FAIL divu_zero: got lo=%h hi=%h want ffffffff 00000007", lo, hi); end
        tick();
        issue(3'd2, 32'hFFFFFFF9, 32'd0);
        wait_done(lat);
        n_cmp++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL div_zero: got lo=%h hi=%h want ffffffff fffffff9", lo, hi); end
    endtask

    task automatic test_overflow_mtlo();
        int lat;
        tick();
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat);
        n_cmp++; if (lo !== 32'h80000000 || hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf: got lo=%h hi=%h want 80000000 00000000", lo, hi); end
        issue(3'd5, 32'h1234, 32'h0);
        n_cmp++; if (lo !== 32'h1234 || hi !== 32'h0) begin n_fail++; $display("FAIL mtlo_b2b: got lo=%h hi=%h want 00001234 00000000", lo, hi); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mtlo_b2b_flags: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int seen = 0;
        issue(3'd2, 32'd100, 32'd7);
        repeat (2) tick();
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        wait_done(lat);
        n_cmp++; if (lat != 30) begin n_fail++; $display("FAIL ign_lat: got %0d want 30", lat); end
        n_cmp++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL ign_result: got lo=%h hi=%h want 0000000e 00000002", lo, hi); end
        repeat (40) begin tick(); if (done === 1'b1) seen++; end
        n_cmp++; if (seen != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL ign_second_done: got %0d pulses busy=%b want 0 0", seen, busy); end
    endtask

    task automatic test_cancel();
        int seen = 0;
        issue(3'd3, 32'd1000, 32'd3);
        repeat (4) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL cancel_flags: got busy=%b done=%b want 0 0", busy, done); end
        repeat (40) begin tick(); if (done === 1'b1) seen++; end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL cancel_nodone: got %0d pulses want 0", seen); end
        n_cmp++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL cancel_hilo: got lo=%h hi=%h want 0000000e 00000002", lo, hi); end
        cancel = 1'b1;
        issue(3'd5, 32'h55, 32'h0);
        issue(3'd1, 32'd9, 32'd9);
        cancel = 1'b0;
        n_cmp++; if (lo !== 32'd14 || busy !== 1'b0) begin n_fail++; $display("FAIL cancel_idle: got lo=%h busy=%b want 0000000e 0", lo, busy); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
        #1;
        test_reset();
        test_mtx();
        test_reset_mid();
        test_multu();
        test_mult();
        test_div();
        test_overflow_mtlo();
        test_busy_ignore();
        test_cancel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the MIPS core.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. Also provides single-cycle MTHI and MTLO writes.
- Sits beside the alu in the execute stage. The control unit issues work via a start/busy/done handshake and stalls the PC while busy is high.
- HI/LO read back through the ToReg path for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits. Must be an even number, 8 or greater.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low. Sampled on the clk rising edge; rst=0 resets the block.
- start  in  1  request pulse. Sampled only in IDLE.
- op  in  3  operation select: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO. Codes 6 and 7 are reserved and ignored.
- a  in  WIDTH  operand A: rs (multiplicand or dividend); also the MTHI/MTLO data.
- b  in  WIDTH  operand B: rt (multiplier or divisor).
- cancel  in  1  abort, driven on exception or flush.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: when rst=0 at a rising edge, the block goes to IDLE. busy=0, done=0, hi=0, lo=0, counter=0, and the internal accumulator and quotient are cleared. Reset in the middle of an operation aborts it.
- States are IDLE, CALC and FIX. All outputs are registered.
- IDLE:
  - start=1 with op 0–3 at edge E0: latch operands and go to CALC. busy=1 from E0.
  - For signed ops, latch |a| and |b| and record the result signs: product sign = a[MSB]^b[MSB]; quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
  - start=1 with op 4: hi<=a at E0, busy stays 0, done stays 0.
  - start=1 with op 5: lo<=a at E0, busy stays 0, done stays 0.
  - start=1 with op 6 or 7: no effect.
- CALC runs exactly WIDTH iterations, one per edge (E1..E_WIDTH); the counter counts 0..WIDTH-1.
  - Multiply: radix-2 shift-add on a 2*WIDTH-bit unsigned product.
  - Divide: restoring division producing a WIDTH-bit quotient and remainder.
- FIX, one edge (E_WIDTH+1):
  - Apply sign correction by two's-complement negation.
  - Multiply: hi <= product[2W-1:W], lo <= product[W-1:0].
  - Divide: lo <= quotient, hi <= remainder.
  - Same edge: busy<=0, done<=1. done clears on the next edge. Return to IDLE.
- Latency: results are visible WIDTH+1 cycles after the accepting edge. For WIDTH=32, results are valid after E33.
- A new start is accepted in the cycle done=1 (the block is in IDLE). Back-to-back operations are legal.
- start while busy=1 is ignored. The control unit must hold start until it sees busy.
- hi and lo hold their previous values throughout CALC. They change only in FIX or on MTHI/MTLO.
- Divide by zero (b=0, signed or unsigned): completes with normal latency. Result lo = all ones, hi = a, where hi is the original signed or unsigned dividend.
- Signed overflow (DIV of the most-negative value by -1): lo = most-negative value, hi = 0, no exception. This falls out naturally from the magnitude datapath.
- Operand magnitude of the most-negative value is 2^(WIDTH-1). It is handled as an unsigned WIDTH-bit magnitude, with no extra bit.
- cancel=1:
  - In CALC or FIX: return to IDLE on that edge with busy=0 and done=0; hi/lo are not written.
  - In IDLE: suppresses start.
- Simultaneous events: rst has priority over cancel, and cancel has priority over start.
- Operands a and b may change after the accepting edge without effect.

Test Plan:
- Reset: drive rst=0 for 2 cycles, then release → hi=0, lo=0, busy=0, done=0. Assert rst=0 at E10 of a MULT → busy=0 and hi=lo=0 next cycle.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles, done pulses for exactly 1 cycle, hi=0xFFFFFFFE, lo=0x00000001. busy=1 for cycles 1–32.
- MULT: a=-7 (0xFFFFFFF9), b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42).
- DIV: a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with a=7, b=0 → lo=0xFFFFFFFF, hi=7.
- DIV: a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Then start an MTLO with a=0x1234 in the done cycle → lo=0x1234 one edge later, busy stays 0.
- Start a DIVU, assert cancel at iteration 5 → busy=0 next cycle, done never pulses, hi/lo unchanged. A start with op=2 during busy is ignored, and a second done does not occur.
